queue: RTL and testbench
========================

QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter WIDTH, default 8, sets the data word width in bits.
REQ-002 Parameter DEPTH, default 8, sets the entry count; it SHALL be a power of two, at least 2; AW = log2(DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 push  input  1  enqueue request for data_in this cycle.
REQ-006 pop  input  1  dequeue request this cycle.
REQ-007 data_in  input  WIDTH  word to enqueue.
REQ-008 data_out  output  WIDTH  registered, last dequeued word.
REQ-009 empty  output  1  high when the queue holds 0 entries.
REQ-010 full  output  1  high when the queue holds DEPTH entries.
REQ-011 count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-012 overflow  output  1  one-cycle pulse, rejected push.
REQ-013 underflow  output  1  one-cycle pulse, rejected pop.

Function
REQ-014 The block SHALL be first-in first-out: DEPTH x WIDTH storage, AW-bit write pointer (tail) and read pointer (head).
REQ-015 A pop is accepted when pop=1 and empty=0.
REQ-016 On an accepted pop, at the same edge:
- data_out <= storage[head]
- head advances by 1
REQ-017 data_out SHALL hold its value in every cycle with no accepted pop. Read latency: the word appears on data_out immediately after the accepting edge.
REQ-018 A push is accepted when push=1 and either full=0, or full=1 with a pop accepted in the same cycle.
REQ-019 On an accepted push, at the same edge:
- storage[tail] <= data_in
- tail advances by 1
REQ-020 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 count SHALL update at the same edge:
- +1 on push only
- -1 on pop only
- unchanged on both or neither
REQ-022 empty = (count==0) and full = (count==DEPTH), both consistent with count in every cycle.
REQ-023 Push and pop while empty: the push is accepted; the pop is rejected (no bypass); underflow pulses; data_out holds.
REQ-024 Push and pop while full: both are accepted; count stays DEPTH; full stays 1.
REQ-025 A rejected push (push=1, full=1, no accepted pop) SHALL:
- leave storage, pointers and count unchanged
- drive overflow=1 for exactly the following cycle
REQ-026 A rejected pop (pop=1, empty=1) SHALL:
- leave all state and data_out unchanged
- drive underflow=1 for exactly the following cycle
REQ-027 overflow and underflow SHALL be registered outputs and 0 in every other cycle.

Reset
REQ-028 While reset=0, independent of clk:
- head=0, tail=0, count=0
- data_out=0, overflow=0, underflow=0
- empty=1, full=0
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-030 Storage contents SHALL NOT be reset; with count=0 they are unobservable.
REQ-031 After reset deasserts, the first rising edge with reset=1 SHALL process push and pop normally.

Verification
REQ-032 Reset, then push 0xA4, push 0xC2, pop, pop -> data_out 0xA4 then 0xC2; count 1,2,1,0; empty=1 after the second pop.
REQ-033 Push 0x01..0x08 -> full=1, count=8; push 0xFF -> overflow high one cycle, count 8; drain -> 0x01..0x08 in order, no 0xFF.
REQ-034 Reset then pop -> underflow high one cycle; data_out stays 0x00; count stays 0.
REQ-035 Fill with 0x01..0x08, then push 0x09 with pop in the same cycle -> data_out=0x01, count=8, full=1; drain -> 0x02..0x09.
REQ-036 Stream 20 words 0x10..0x23 with interleaved push/pop, never exceeding 8 stored (pointers wrap twice) -> output order exactly 0x10..0x23, no overflow or underflow pulses.
REQ-037 With 3 entries stored, drive reset=0 between clock edges -> empty=1, count=0, data_out=0x00 without waiting for a clock edge; after release, push 0x55, pop -> data_out=0x55.

Source files
------------

// File: rtl/queue.sv
// queue: synchronous FIFO with registered read data and overflow/underflow pulses.
module queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             do_push, do_pop;
  always_comb begin
    empty   = count_q == '0;
    full    = count_q == (AW+1)'(DEPTH);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head_d  = do_pop ? head_q + AW'(1) : head_q;
    tail_d  = do_push ? tail_q + AW'(1) : tail_q;
    count_d = (do_push && !do_pop) ? count_q + (AW+1)'(1) :
              (do_pop && !do_push) ? count_q - (AW+1)'(1) : count_q;
    data_d  = do_pop ? mem[head_q] : data_q;
    ovf_d   = push && !do_push;
    unf_d   = pop && empty;
  end
  // Storage is deliberately left out of reset; count gates its visibility.
  always_ff @(posedge clk) if (do_push) mem[tail_q] <= data_in;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  assign data_out  = data_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: tb/tb_queue.sv
// tb_queue: directed vectors for queue with hand-computed expectations.
module tb_queue;
  logic       clk = 1'b0, reset = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       empty, full, overflow, underflow;
  logic [3:0] count;
  int         n_vec = 0, n_err = 0;
  logic       flag;
  queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop = q;
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_flags", {overflow, underflow}, 0);
    #6 reset = 1'b1;
    cyc(1, 0, 8'hA4); chk("b_cnt1", count, 1);
    cyc(1, 0, 8'hC2); chk("b_cnt2", count, 2);
    cyc(0, 1, 8'h00); chk("b_d1", data_out, 8'hA4); chk("b_cnt3", count, 1);
    cyc(0, 1, 8'h00); chk("b_d2", data_out, 8'hC2); chk("b_cnt4", count, 0);
    chk("b_empty", empty, 1);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    cyc(0, 1, 8'h00);
    chk("u_pulse", underflow, 1); chk("u_dout", data_out, 0); chk("u_cnt", count, 0);
    cyc(0, 0, 8'h00); chk("u_clear", underflow, 0);
    cyc(1, 1, 8'h77);
    chk("ep_cnt", count, 1); chk("ep_unf", underflow, 1); chk("ep_dout", data_out, 0);
    cyc(0, 1, 8'h00); chk("ep_pop", data_out, 8'h77); chk("ep_empty", empty, 1);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
    chk("o_full", full, 1); chk("o_cnt", count, 8);
    cyc(1, 0, 8'hFF); chk("o_pulse", overflow, 1); chk("o_cnt2", count, 8);
    cyc(0, 0, 8'h00); chk("o_clear", overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00);
      chk("o_drain", data_out, i);
    end
    chk("o_empty", empty, 1);
    for (int i = 1; i <= 8; i++) cyc(1, 0, 8'(i));
    cyc(1, 1, 8'h09);
    chk("f_dout", data_out, 1); chk("f_cnt", count, 8); chk("f_full", full, 1);
    chk("f_ovf", overflow, 0);
    for (int i = 2; i <= 9; i++) begin
      cyc(0, 1, 8'h00);
      chk("f_drain", data_out, i);
    end
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'(8'h10 + i));
      flag |= overflow | underflow;
    end
    for (int i = 0; i < 15; i++) begin
      cyc(1, 1, 8'(8'h15 + i));
      chk("s_mid", data_out, 8'h10 + i);
      flag |= overflow | underflow;
    end
    chk("s_cnt", count, 5);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'h00);
      chk("s_tail", data_out, 8'h1F + i);
      flag |= overflow | underflow;
    end
    chk("s_flags", flag, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h60 + i));
    chk("r_pre", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("r_empty", empty, 1); chk("r_cnt", count, 0); chk("r_dout", data_out, 0);
    #1 reset = 1'b1;
    cyc(1, 0, 8'h55);
    cyc(0, 1, 8'h00); chk("r_after", data_out, 8'h55); chk("r_cnt2", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
